pool_2x2_stage: RTL and testbench
=================================

Name: pool_2x2_stage

Overview:
- 2x2 stride-2 pooling stage, directly downstream of the pre-pooling pipeline stage.
- Consumes its NPX-lane output stream and reduces each 2x2 pixel window to one pixel (max; average optional).
- Horizontal pairs are reduced within a beat; vertical pairs via a one-row line buffer.
- Two odd-row beats are packed into one NPX-lane output beat toward the wrapper sink.

Parameters:
NPX, 4, pixels per beat; even, >=2
AXI_WIDTH, 32, bits per pixel lane, signed two's complement
MAX_WIDTH, 512, max feature width in pixels; line buffer depth = MAX_WIDTH/NPX entries of (NPX/2)*AXI_WIDTH bits

Ports:
clk_gated  in  1  clock
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous soft clear, same effect as reset
start_i  in  1  one-cycle pulse, latches config, begins feature
image_width_i  in  16  input feature width in pixels
feat_height_i  in  16  input feature height in rows
y_in_TVALID_i  in  1  upstream valid
y_in_TREADY_o  out  1  upstream ready
y_in_TDATA_i  in  NPX*AXI_WIDTH  pixels, lane 0 = leftmost
pool_out_TVALID_o  out  1  output valid
pool_out_TREADY_i  in  1  sink ready
pool_out_TDATA_o  out  NPX*AXI_WIDTH  pooled pixels, lane 0 = leftmost
done_o  out  1  one-cycle pulse, feature complete
err_o  out  1  sticky config error, cleared by next valid start_i, reset or clear

Behaviour:
- Reset/clear: state IDLE, all counters 0, y_in_TREADY_o=0, pool_out_TVALID_o=0, pool_out_TDATA_o=0, done_o=0, err_o=0. Mid-operation reset/clear discards line buffer contents and any pending output beat.
- Config check at start_i: image_width_i nonzero, multiple of 2*NPX and <= MAX_WIDTH; feat_height_i >= 2. Failure: err_o=1, remain IDLE. start_i outside IDLE is ignored.
- States: IDLE -> EVEN_ROW on valid start; EVEN_ROW -> ODD_ROW after last beat of row; ODD_ROW -> EVEN_ROW after last beat of row if rows remain.
- If feat_height_i is odd, the trailing row is accepted through state TAIL and discarded, producing no output.
- After the final pair row (or TAIL row): DRAIN until the output register is empty, then done_o pulses for one cycle and the block returns to IDLE.
- Beat counter col counts 0..image_width_i/NPX-1. Row counter counts rows consumed.
- Horizontal reduction: h[k] = max(px[2k], px[2k+1]) for k = 0..NPX/2-1, signed compare.
- EVEN_ROW: y_in_TREADY_o=1. On each handshake, write h into line buffer at address col.
- ODD_ROW: v[k] = max(h[k], lb[col][k]).
  - Even col: v goes to half register lo.
  - Odd col: output data = {v, lo}, with lo in lanes 0..NPX/2-1.
- Output register: pool_out_TDATA_o is registered. Valid asserts the cycle after the odd-col handshake and holds stable until pool_out_TREADY_i.
- ODD_ROW ready rule: on odd col, y_in_TREADY_o = !pool_out_TVALID_o || pool_out_TREADY_i, allowing same-cycle drain and refill. On even col, ready=1.
- TAIL and DRAIN ready: TAIL ready=1; DRAIN ready=0.
- Line buffer read is combinational on col, or registered with one-beat prefetch; either way it must be invisible at the ports.
- No valid/ready combinational path from pool_out_TREADY_i to data. TREADY may depend combinationally on pool_out_TREADY_i.
- Throughput: one input beat per cycle when sink is always ready.

Optional Feature:
POOL_AVG_EN
- Defined: adds port mode_i (in, 1), latched at start_i. 0 = max; 1 = average.
- Average = (a+b+c+d) computed at AXI_WIDTH+2 bits, arithmetic shift right 2 (floor), truncated to AXI_WIDTH.
- Line buffer stores horizontal sums at AXI_WIDTH+1 bits.
- Undefined: max only, no mode_i port, line buffer lanes are AXI_WIDTH bits.

Decomposition:
- Shared package: state enum fsm_pool2x2 {IDLE_PL, EVEN_ROW_PL, ODD_ROW_PL, TAIL_PL, DRAIN_PL}; constant POOL_WIN=2.
- Sub-module: pool_line_buffer (single-port write/read, depth MAX_WIDTH/NPX, width param).

Test Plan:
- Basic max (NPX=4, width 8, height 2):
  - Stimulus: row0 [1,5,2,3],[-4,0,7,7]; row1 [2,2,9,1],[0,-1,6,8].
  - Response: one output beat {5,9,0,8} (lane0 first), then done_o 1 cycle after acceptance.
- Backpressure: same stimulus, pool_out_TREADY_i=0 for 5 cycles. Data holds {5,9,0,8}; next odd-col beat is stalled via y_in_TREADY_o=0; no loss or duplication.
- Odd height 3 width 8: third row consumed (TREADY=1 for 2 beats), no extra output; done_o after the first output is accepted.
- Config error: width 12, NPX=4 -> err_o=1, TREADY stays 0. A following valid start clears err_o.
- Reset mid-ODD_ROW with output pending: next cycle valid=0, TREADY=0, state IDLE. A fresh feature then pools correctly with no stale line-buffer data.
- POOL_AVG_EN, mode 1: window {-1,-2,-3,-4} -> -3 (floor of -2.5); window {1,2,3,5} -> 2.

Source files
------------

// File: rtl/pool_2x2_stage_pkg.sv
// pool_2x2_stage_pkg: shared FSM state type and window constant for the 2x2 pooling stage.
package pool_2x2_stage_pkg;
    typedef enum logic [2:0] {IDLE_PL, EVEN_ROW_PL, ODD_ROW_PL, TAIL_PL, DRAIN_PL} fsm_pool2x2;
    localparam int POOL_WIN = 2;
endpackage

// File: rtl/pool_2x2_stage_line_buffer.sv
// pool_line_buffer: one-row line buffer, shared write/read address, combinational read.
module pool_line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 64,
    parameter int AW    = 7
) (
    input  logic             clk_gated,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk_gated) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/pool_2x2_stage.sv
// pool_2x2_stage: 2x2 stride-2 pooling over an NPX-lane pixel stream (max; average when
// POOL_AVG_EN is defined, selected by mode_i).
module pool_2x2_stage
    import pool_2x2_stage_pkg::*;
#(
    parameter int NPX       = 4,
    parameter int AXI_WIDTH = 32,
    parameter int MAX_WIDTH = 512
) (
    input  logic                     clk_gated,
    input  logic                     rst_n,
    input  logic                     clear,
`ifdef POOL_AVG_EN
    input  logic                     mode_i,
`endif
    input  logic                     start_i,
    input  logic [15:0]              image_width_i,
    input  logic [15:0]              feat_height_i,
    input  logic                     y_in_TVALID_i,
    output logic                     y_in_TREADY_o,
    input  logic [NPX*AXI_WIDTH-1:0] y_in_TDATA_i,
    output logic                     pool_out_TVALID_o,
    input  logic                     pool_out_TREADY_i,
    output logic [NPX*AXI_WIDTH-1:0] pool_out_TDATA_o,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int HN = NPX / POOL_WIN;
`ifdef POOL_AVG_EN
    localparam int LW = AXI_WIDTH + 1;
`else
    localparam int LW = AXI_WIDTH;
`endif
    localparam int DEPTH = MAX_WIDTH / NPX;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [15:0] NPX16 = 16'(NPX);
    localparam logic [15:0] PAIR16 = 16'(2 * NPX);
    localparam logic [15:0] MAXW16 = 16'(MAX_WIDTH);

    fsm_pool2x2 state_q, state_d;
    logic [15:0] col_q, col_d, row_q, row_d, last_col_q, last_col_d, height_q, height_d;
    logic [HN*AXI_WIDTH-1:0] lo_q, lo_d;
    logic ov_q, ov_d, done_q, done_d, err_q, err_d;
    logic [NPX*AXI_WIDTH-1:0] od_q, od_d;
    logic [HN*LW-1:0] h_st, lb_rdata;
    logic [HN*AXI_WIDTH-1:0] v_all;
    logic [15:0] rem;
    logic cfg_ok, hs_in, row_end, lb_we;
`ifdef POOL_AVG_EN
    logic mode_q, mode_d;
`endif

    for (genvar k = 0; k < HN; k++) begin : g_lane
        logic signed [AXI_WIDTH-1:0] a, b, hm, l, vm;
        assign a  = y_in_TDATA_i[2*k*AXI_WIDTH +: AXI_WIDTH];
        assign b  = y_in_TDATA_i[(2*k+1)*AXI_WIDTH +: AXI_WIDTH];
        assign hm = a > b ? a : b;
        assign l  = lb_rdata[k*LW +: AXI_WIDTH];
        assign vm = hm > l ? hm : l;
`ifdef POOL_AVG_EN
        logic [LW-1:0] hs;
        logic [AXI_WIDTH+1:0] s4;
        assign hs = {a[AXI_WIDTH-1], a} + {b[AXI_WIDTH-1], b};
        assign s4 = {hs[LW-1], hs} + {lb_rdata[k*LW+LW-1], lb_rdata[k*LW +: LW]};
        // max mode keeps sign-extended maxima so the low AXI_WIDTH bits read back unchanged
        assign h_st[k*LW +: LW] = mode_q ? hs : {hm[AXI_WIDTH-1], hm};
        assign v_all[k*AXI_WIDTH +: AXI_WIDTH] = mode_q ? AXI_WIDTH'(s4 >> 2) : vm;
`else
        assign h_st[k*LW +: LW] = hm;
        assign v_all[k*AXI_WIDTH +: AXI_WIDTH] = vm;
`endif
    end

    pool_line_buffer #(.DEPTH(DEPTH), .WIDTH(HN*LW), .AW(AW)) u_lb (
        .clk_gated (clk_gated),
        .we_i      (lb_we),
        .addr_i    (col_q[AW-1:0]),
        .wdata_i   (h_st),
        .rdata_o   (lb_rdata)
    );

    assign cfg_ok = image_width_i != 16'd0 && (image_width_i % PAIR16) == 16'd0 &&
                    image_width_i <= MAXW16 && feat_height_i >= 16'd2;
    assign y_in_TREADY_o = state_q == EVEN_ROW_PL || state_q == TAIL_PL ||
                           (state_q == ODD_ROW_PL && (!col_q[0] || !ov_q || pool_out_TREADY_i));
    assign hs_in = y_in_TVALID_i && y_in_TREADY_o;
    assign row_end = hs_in && col_q == last_col_q;
    assign lb_we = hs_in && state_q == EVEN_ROW_PL;
    assign rem = height_q - row_q - 16'd1;

    always_comb begin
        state_d = state_q;
        col_d = hs_in ? (row_end ? 16'd0 : col_q + 16'd1) : col_q;
        row_d = row_end ? row_q + 16'd1 : row_q;
        last_col_d = last_col_q;
        height_d = height_q;
        lo_d = lo_q;
        ov_d = ov_q && !pool_out_TREADY_i;
        od_d = od_q;
        done_d = 1'b0;
        err_d = err_q;
`ifdef POOL_AVG_EN
        mode_d = mode_q;
`endif
        case (state_q)
            IDLE_PL: if (start_i) begin
                err_d = !cfg_ok;
                if (cfg_ok) begin
                    state_d = EVEN_ROW_PL;
                    col_d = 16'd0;
                    row_d = 16'd0;
                    last_col_d = image_width_i / NPX16 - 16'd1;
                    height_d = feat_height_i;
`ifdef POOL_AVG_EN
                    mode_d = mode_i;
`endif
                end
            end
            EVEN_ROW_PL: if (row_end) state_d = ODD_ROW_PL;
            ODD_ROW_PL: begin
                if (hs_in && !col_q[0]) lo_d = v_all;
                if (hs_in && col_q[0]) begin
                    ov_d = 1'b1;
                    od_d = {v_all, lo_q};
                end
                if (row_end) state_d = rem >= 16'd2 ? EVEN_ROW_PL : rem == 16'd1 ? TAIL_PL : DRAIN_PL;
            end
            TAIL_PL: if (row_end) state_d = DRAIN_PL;
            DRAIN_PL: if (!ov_q || pool_out_TREADY_i) begin
                done_d = 1'b1;
                state_d = IDLE_PL;
            end
            default: state_d = IDLE_PL;
        endcase
    end

    always_ff @(posedge clk_gated) begin
        if (!rst_n || clear) begin
            state_q <= IDLE_PL;
            col_q <= '0;
            row_q <= '0;
            last_col_q <= '0;
            height_q <= '0;
            lo_q <= '0;
            ov_q <= 1'b0;
            od_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            row_q <= row_d;
            last_col_q <= last_col_d;
            height_q <= height_d;
            lo_q <= lo_d;
            ov_q <= ov_d;
            od_q <= od_d;
            done_q <= done_d;
            err_q <= err_d;
`ifdef POOL_AVG_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign pool_out_TVALID_o = ov_q;
    assign pool_out_TDATA_o = od_q;
    assign done_o = done_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_pool_2x2_stage.sv
// tb_pool_2x2_stage: directed self-checking bench for pool_2x2_stage (NPX=4, AXI_WIDTH=32).
module tb_pool_2x2_stage;
    localparam int DW = 128;
    logic clk_gated = 1'b0, rst_n = 1'b0, clear = 1'b0, start_i = 1'b0;
    logic [15:0] image_width_i = '0, feat_height_i = '0;
    logic y_valid = 1'b0, y_ready, out_valid, sink_ready = 1'b1, done_o, err_o;
    logic [DW-1:0] y_data = '0, out_data;
`ifdef POOL_AVG_EN
    logic mode_i = 1'b0;
`endif
    int vec = 0, miss = 0, cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    logic [DW-1:0] outq [$];

    pool_2x2_stage dut (
        .clk_gated         (clk_gated),
        .rst_n             (rst_n),
        .clear             (clear),
`ifdef POOL_AVG_EN
        .mode_i            (mode_i),
`endif
        .start_i           (start_i),
        .image_width_i     (image_width_i),
        .feat_height_i     (feat_height_i),
        .y_in_TVALID_i     (y_valid),
        .y_in_TREADY_o     (y_ready),
        .y_in_TDATA_i      (y_data),
        .pool_out_TVALID_o (out_valid),
        .pool_out_TREADY_i (sink_ready),
        .pool_out_TDATA_o  (out_data),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    always #5 clk_gated = ~clk_gated;
    always @(posedge clk_gated) cyc++;
    always @(negedge clk_gated) begin
        if (out_valid && sink_ready) begin
            outq.push_back(out_data);
            acc_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [DW-1:0] q_at(input int i);
        return outq.size() > i ? outq[i] : 'x;
    endfunction

    task automatic start(input int w, input int h);
        image_width_i = 16'(w);
        feat_height_i = 16'(h);
        start_i = 1'b1;
        @(posedge clk_gated); #1;
        start_i = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, output int stalls);
        int n = 0;
        y_valid = 1'b1;
        y_data = d;
        @(negedge clk_gated);
        while (!y_ready && n < 50) begin
            n++;
            @(negedge clk_gated);
        end
        @(posedge clk_gated); #1;
        y_valid = 1'b0;
        stalls = n;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk_gated);
            n++;
        end
        repeat (2) @(negedge clk_gated);
        @(posedge clk_gated); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_gated);
        @(negedge clk_gated);
        vec++; if (y_ready !== 1'b0) begin miss++; $display("FAIL rst_ready got %b want 0", y_ready); end
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rst_valid got %b want 0", out_valid); end
        vec++; if (out_data !== '0) begin miss++; $display("FAIL rst_data got %h want 0", out_data); end
        vec++; if (done_o !== 1'b0) begin miss++; $display("FAIL rst_done got %b want 0", done_o); end
        vec++; if (err_o !== 1'b0) begin miss++; $display("FAIL rst_err got %b want 0", err_o); end
        @(posedge clk_gated); #1;
        rst_n = 1'b1;
        @(negedge clk_gated);
        vec++; if (y_ready !== 1'b0) begin miss++; $display("FAIL idle_ready got %b want 0", y_ready); end
        @(posedge clk_gated); #1;
    endtask

    task automatic test_basic_max();
        int s, st = 0, d0 = done_cnt;
        outq.delete();
        sink_ready = 1'b1;
        start(8, 2);
        send(pk(1, 5, 2, 3), s); st += s;
        send(pk(-4, 0, 7, 7), s); st += s;
        send(pk(2, 2, 9, 1), s); st += s;
        send(pk(0, -1, 6, 8), s); st += s;
        wait_done();
        vec++; if (st !== 0) begin miss++; $display("FAIL basic_stalls got %0d want 0", st); end
        vec++; if (outq.size() !== 1) begin miss++; $display("FAIL basic_count got %0d want 1", outq.size()); end
        vec++; if (q_at(0) !== pk(5, 9, 0, 8)) begin miss++; $display("FAIL basic_data got %h want %h", q_at(0), pk(5, 9, 0, 8)); end
        vec++; if (done_cnt - d0 !== 1) begin miss++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt - d0); end
        vec++; if (done_cyc - acc_cyc !== 1) begin miss++; $display("FAIL basic_done_lat got %0d want 1", done_cyc - acc_cyc); end
    endtask

    task automatic test_backpressure();
        int s, st = 0, s3 = 0, d0 = done_cnt;
        outq.delete();
        sink_ready = 1'b0;
        start(16, 2);
        send(pk(1, 5, 2, 3), s); st += s;
        send(pk(-4, 0, 7, 7), s); st += s;
        send(pk(10, -10, 3, 4), s); st += s;
        send(pk(-7, -8, 100, -100), s); st += s;
        send(pk(2, 2, 9, 1), s); st += s;
        send(pk(0, -1, 6, 8), s); st += s;
        send(pk(-20, 11, 0, 0), s); st += s;
        fork
            send(pk(-6, -9, 50, 60), s3);
            begin
                repeat (5) begin
                    @(negedge clk_gated);
                    vec++;
                    if ({out_valid, y_ready, out_data} !== {1'b1, 1'b0, pk(5, 9, 0, 8)}) begin
                        miss++;
                        $display("FAIL bp_hold got v=%b r=%b d=%h want v=1 r=0 d=%h", out_valid, y_ready, out_data, pk(5, 9, 0, 8));
                    end
                end
                @(posedge clk_gated); #1;
                sink_ready = 1'b1;
            end
        join
        wait_done();
        vec++; if (st !== 0) begin miss++; $display("FAIL bp_free_stalls got %0d want 0", st); end
        vec++; if (s3 !== 5) begin miss++; $display("FAIL bp_stall got %0d want 5", s3); end
        vec++; if (outq.size() !== 2) begin miss++; $display("FAIL bp_count got %0d want 2", outq.size()); end
        vec++; if (q_at(0) !== pk(5, 9, 0, 8)) begin miss++; $display("FAIL bp_data0 got %h want %h", q_at(0), pk(5, 9, 0, 8)); end
        vec++; if (q_at(1) !== pk(11, 4, -6, 100)) begin miss++; $display("FAIL bp_data1 got %h want %h", q_at(1), pk(11, 4, -6, 100)); end
        vec++; if (done_cnt - d0 !== 1) begin miss++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_odd_height();
        int s, st = 0, d0 = done_cnt;
        outq.delete();
        sink_ready = 1'b1;
        start(8, 3);
        send(pk(1, 5, 2, 3), s);
        send(pk(-4, 0, 7, 7), s);
        send(pk(2, 2, 9, 1), s);
        send(pk(0, -1, 6, 8), s);
        send(pk(100, 100, 100, 100), s); st += s;
        send(pk(99, 99, 99, 99), s); st += s;
        wait_done();
        vec++; if (st !== 0) begin miss++; $display("FAIL tail_stalls got %0d want 0", st); end
        vec++; if (outq.size() !== 1) begin miss++; $display("FAIL tail_count got %0d want 1", outq.size()); end
        vec++; if (q_at(0) !== pk(5, 9, 0, 8)) begin miss++; $display("FAIL tail_data got %h want %h", q_at(0), pk(5, 9, 0, 8)); end
        vec++; if (done_cnt - d0 !== 1) begin miss++; $display("FAIL tail_done_cnt got %0d want 1", done_cnt - d0); end
        vec++; if (done_cyc <= acc_cyc) begin miss++; $display("FAIL tail_done_order got done=%0d acc=%0d want done after acc", done_cyc, acc_cyc); end
    endtask

    task automatic test_config_error();
        int s;
        int bw [4] = '{12, 0, 520, 8};
        int bh [4] = '{2, 2, 2, 1};
        for (int i = 0; i < 4; i++) begin
            start(bw[i], bh[i]);
            repeat (2) @(negedge clk_gated);
            vec++; if ({err_o, y_ready} !== 2'b10) begin miss++; $display("FAIL cfg_err%0d got err=%b rdy=%b want err=1 rdy=0", i, err_o, y_ready); end
            @(posedge clk_gated); #1;
        end
        outq.delete();
        start(8, 2);
        @(negedge clk_gated);
        vec++; if ({err_o, y_ready} !== 2'b01) begin miss++; $display("FAIL cfg_clear got err=%b rdy=%b want err=0 rdy=1", err_o, y_ready); end
        @(posedge clk_gated); #1;
        send(pk(1, 5, 2, 3), s);
        send(pk(-4, 0, 7, 7), s);
        send(pk(2, 2, 9, 1), s);
        send(pk(0, -1, 6, 8), s);
        wait_done();
        vec++; if (q_at(0) !== pk(5, 9, 0, 8)) begin miss++; $display("FAIL cfg_data got %h want %h", q_at(0), pk(5, 9, 0, 8)); end
    endtask

    task automatic test_reset_mid_odd();
        int s;
        outq.delete();
        sink_ready = 1'b0;
        start(16, 2);
        send(pk(1, 5, 2, 3), s);
        send(pk(-4, 0, 7, 7), s);
        send(pk(10, -10, 3, 4), s);
        send(pk(-7, -8, 100, -100), s);
        send(pk(2, 2, 9, 1), s);
        send(pk(0, -1, 6, 8), s);
        @(negedge clk_gated);
        vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL mid_pending got %b want 1", out_valid); end
        rst_n = 1'b0;
        @(posedge clk_gated); #1;
        rst_n = 1'b1;
        @(negedge clk_gated);
        vec++; if ({out_valid, y_ready} !== 2'b00) begin miss++; $display("FAIL mid_rst got v=%b r=%b want 00", out_valid, y_ready); end
        vec++; if (out_data !== '0) begin miss++; $display("FAIL mid_rst_data got %h want 0", out_data); end
        sink_ready = 1'b1;
        @(posedge clk_gated); #1;
        start(8, 2);
        send(pk(-9, -8, -7, -6), s);
        send(pk(-5, -4, -3, -2), s);
        send(pk(-20, -30, -40, -50), s);
        send(pk(-60, -70, -80, -90), s);
        wait_done();
        vec++; if (outq.size() !== 1) begin miss++; $display("FAIL mid_count got %0d want 1", outq.size()); end
        vec++; if (q_at(0) !== pk(-8, -6, -4, -2)) begin miss++; $display("FAIL mid_data got %h want %h", q_at(0), pk(-8, -6, -4, -2)); end
        start(8, 2);
        send(pk(1, 1, 1, 1), s);
        clear = 1'b1;
        @(posedge clk_gated); #1;
        clear = 1'b0;
        @(negedge clk_gated);
        vec++; if ({y_ready, out_valid, err_o} !== 3'b000) begin miss++; $display("FAIL clear_idle got r=%b v=%b e=%b want 000", y_ready, out_valid, err_o); end
        @(posedge clk_gated); #1;
    endtask

`ifdef POOL_AVG_EN
    task automatic test_average();
        int s;
        outq.delete();
        mode_i = 1'b1;
        start(8, 2);
        mode_i = 1'b0;
        send(pk(-1, -2, 1, 2), s);
        send(pk(0, 0, 0, 0), s);
        send(pk(-3, -4, 3, 5), s);
        send(pk(0, 0, 0, 0), s);
        wait_done();
        vec++; if (q_at(0) !== pk(-3, 2, 0, 0)) begin miss++; $display("FAIL avg_data got %h want %h", q_at(0), pk(-3, 2, 0, 0)); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_max();
        test_backpressure();
        test_odd_height();
        test_config_error();
        test_reset_mid_odd();
`ifdef POOL_AVG_EN
        test_average();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
